// File: rtl/game_para_smooth.sv
// Attention/meditation moving-average smoother that steps two game levels once per tick.
// Optional hysteresis margin enabled by defining GAME_PARA_HYST_EN.
module game_para_smooth #(
  parameter int DATA_W   = 8,
  parameter int LVL_W    = 3,
  parameter int AVG_LOG2 = 2,
  parameter int HYST     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] attention_data,
  input  logic [DATA_W-1:0] meditation_data,
  input  logic              tick_1s,
  input  logic              freeze,
  output logic [LVL_W-1:0]  snake_speed,
  output logic [LVL_W-1:0]  apple_size,
  output logic              level_chg,
  output logic              warm,
  output logic [1:0]        state_dbg
);

  // Handshake: sample_valid and tick_1s are single-cycle strobes with no ready;
  // every asserted cycle is consumed, so the source never stalls.

  localparam int D     = 1 << AVG_LOG2;
  localparam int SUM_W = DATA_W + AVG_LOG2;
  localparam int TW    = DATA_W + 1;
  localparam int SH    = DATA_W - LVL_W;

  localparam logic [LVL_W-1:0]  LMAX      = '1;
  localparam logic [AVG_LOG2:0] FILL_FULL = (AVG_LOG2 + 1)'(D);
  localparam logic [AVG_LOG2:0] FILL_LAST = (AVG_LOG2 + 1)'(D - 1);

`ifdef GAME_PARA_HYST_EN
  localparam logic [TW-1:0] HYST_M = TW'(HYST);
`else
  localparam logic [TW-1:0] HYST_M = '0;
`endif

  typedef enum logic [1:0] {
    ST_WARM = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   buf_a_q [D];
  logic [DATA_W-1:0]   buf_a_d [D];
  logic [DATA_W-1:0]   buf_m_q [D];
  logic [DATA_W-1:0]   buf_m_d [D];
  logic [AVG_LOG2-1:0] wp_q, wp_d;
  logic [AVG_LOG2:0]   fill_q, fill_d;
  logic [SUM_W-1:0]    sum_a_q, sum_a_d;
  logic [SUM_W-1:0]    sum_m_q, sum_m_d;
  logic [LVL_W-1:0]    lvl_a_q, lvl_a_d;
  logic [LVL_W-1:0]    lvl_m_q, lvl_m_d;
  logic                chg_q, chg_d;
  logic                warm_q, warm_d;

  logic [DATA_W-1:0]   avg_a, avg_m;

  // Averages come from the registered sums, so a same-cycle sample never affects a tick.
  assign avg_a = sum_a_q[SUM_W-1:AVG_LOG2];
  assign avg_m = sum_m_q[SUM_W-1:AVG_LOG2];

  // Compares are done one bit wider than the data so thr(LMAX+1) and avg+HYST never wrap.
  function automatic logic [LVL_W-1:0] step_lvl(input logic [LVL_W-1:0]  lvl,
                                               input logic [DATA_W-1:0] avg);
    logic [TW-1:0] avg_w;
    logic [TW-1:0] thr_up;
    logic [TW-1:0] thr_dn;
    avg_w  = {1'b0, avg};
    thr_up = (TW'(lvl) + TW'(1)) << SH;
    thr_dn = TW'(lvl) << SH;
    step_lvl = lvl;
    if (lvl != LMAX && avg_w >= thr_up + HYST_M) begin
      step_lvl = lvl + LVL_W'(1);
    end else if (lvl != '0 && avg_w + HYST_M < thr_dn) begin
      step_lvl = lvl - LVL_W'(1);
    end
  endfunction

  always_comb begin
    state_d = state_q;
    buf_a_d = buf_a_q;
    buf_m_d = buf_m_q;
    wp_d    = wp_q;
    fill_d  = fill_q;
    sum_a_d = sum_a_q;
    sum_m_d = sum_m_q;
    lvl_a_d = lvl_a_q;
    lvl_m_d = lvl_m_q;
    chg_d   = 1'b0;
    warm_d  = warm_q;

    if (sample_valid) begin
      sum_a_d = sum_a_q + SUM_W'(attention_data) - SUM_W'(buf_a_q[wp_q]);
      sum_m_d = sum_m_q + SUM_W'(meditation_data) - SUM_W'(buf_m_q[wp_q]);
      buf_a_d[wp_q] = attention_data;
      buf_m_d[wp_q] = meditation_data;
      wp_d = wp_q + AVG_LOG2'(1);
      if (fill_q != FILL_FULL) begin
        fill_d = fill_q + (AVG_LOG2 + 1)'(1);
      end
    end

    case (state_q)
      ST_WARM: begin
        if (sample_valid && fill_q == FILL_LAST) begin
          warm_d  = 1'b1;
          state_d = freeze ? ST_HOLD : ST_RUN;
        end
      end
      ST_RUN: begin
        if (tick_1s) begin
          lvl_a_d = step_lvl(lvl_a_q, avg_a);
          lvl_m_d = step_lvl(lvl_m_q, avg_m);
          chg_d   = (lvl_a_d != lvl_a_q) || (lvl_m_d != lvl_m_q);
        end
        if (freeze) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!freeze) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_WARM;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_WARM;
      for (int i = 0; i < D; i++) begin
        buf_a_q[i] <= '0;
        buf_m_q[i] <= '0;
      end
      wp_q    <= '0;
      fill_q  <= '0;
      sum_a_q <= '0;
      sum_m_q <= '0;
      lvl_a_q <= '0;
      lvl_m_q <= '0;
      chg_q   <= 1'b0;
      warm_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_a_q <= buf_a_d;
      buf_m_q <= buf_m_d;
      wp_q    <= wp_d;
      fill_q  <= fill_d;
      sum_a_q <= sum_a_d;
      sum_m_q <= sum_m_d;
      lvl_a_q <= lvl_a_d;
      lvl_m_q <= lvl_m_d;
      chg_q   <= chg_d;
      warm_q  <= warm_d;
    end
  end

  assign snake_speed = lvl_a_q;
  assign apple_size  = lvl_m_q;
  assign level_chg   = chg_q;
  assign warm        = warm_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_game_para_smooth.sv
// Self-checking bench for game_para_smooth: scenario tasks plus a randomized run
// against a queue-based moving-average reference model.
module tb_game_para_smooth;

  localparam int DATA_W = 8;
  localparam int LVL_W  = 3;
  localparam int D      = 4;
  localparam int S      = 1 << (DATA_W - LVL_W);
  localparam int LMAX   = (1 << LVL_W) - 1;
`ifdef GAME_PARA_HYST_EN
  localparam int HM = 4;
`else
  localparam int HM = 0;
`endif
  localparam int VW = 2 * LVL_W + 2;

  logic              clk;
  logic              rst;
  logic              sample_valid;
  logic [DATA_W-1:0] attention_data;
  logic [DATA_W-1:0] meditation_data;
  logic              tick_1s;
  logic              freeze;
  logic [LVL_W-1:0]  snake_speed;
  logic [LVL_W-1:0]  apple_size;
  logic              level_chg;
  logic              warm;
  logic [1:0]        state_dbg;

  game_para_smooth dut (
    .clk             (clk),
    .rst             (rst),
    .sample_valid    (sample_valid),
    .attention_data  (attention_data),
    .meditation_data (meditation_data),
    .tick_1s         (tick_1s),
    .freeze          (freeze),
    .snake_speed     (snake_speed),
    .apple_size      (apple_size),
    .level_chg       (level_chg),
    .warm            (warm),
    .state_dbg       (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: last D samples per channel, levels, warm/hold flags
  int qa[$];
  int qm[$];
  int m_cnt;
  int m_la, m_lm;
  bit m_warm, m_hold, m_chg;
  logic [VW-1:0] exp_q[$];

  function automatic int q_avg(input bit sel_m);
    int s;
    s = 0;
    for (int i = 0; i < D; i++) s += sel_m ? qm[i] : qa[i];
    return s / D;
  endfunction

  function automatic int step_ref(input int l, input int avg);
    if (l < LMAX && avg >= (l + 1) * S + HM) return l + 1;
    if (l > 0 && avg + HM < l * S) return l - 1;
    return l;
  endfunction

  function automatic logic [VW-1:0] model_vec();
    return {LVL_W'(m_la), LVL_W'(m_lm), m_chg, m_warm};
  endfunction

  task automatic model_reset();
    qa.delete();
    qm.delete();
    for (int i = 0; i < D; i++) begin
      qa.push_back(0);
      qm.push_back(0);
    end
    m_cnt = 0; m_la = 0; m_lm = 0;
    m_warm = 0; m_hold = 0; m_chg = 0;
  endtask

  task automatic model_edge(input bit sv, input int a, input int m, input bit tk, input bit fz);
    bit old_warm;
    int aa, am, na, nm;
    old_warm = m_warm;
    aa = q_avg(0);
    am = q_avg(1);
    m_chg = 0;
    if (old_warm && !m_hold && tk) begin
      na = step_ref(m_la, aa);
      nm = step_ref(m_lm, am);
      m_chg = (na != m_la) || (nm != m_lm);
      m_la = na;
      m_lm = nm;
    end
    if (old_warm) m_hold = fz;
    if (sv) begin
      void'(qa.pop_front());
      void'(qm.pop_front());
      qa.push_back(a & 255);
      qm.push_back(m & 255);
      if (m_cnt < D) m_cnt++;
      if (!old_warm && m_cnt == D) begin
        m_warm = 1;
        m_hold = fz;
      end
    end
  endtask

  // driver tasks
  task automatic drive(input bit sv, input int a, input int m, input bit tk, input bit fz);
    sample_valid    = sv;
    attention_data  = DATA_W'(a);
    meditation_data = DATA_W'(m);
    tick_1s         = tk;
    freeze          = fz;
    @(posedge clk);
    model_edge(sv, a, m, tk, fz);
    #1;
    sample_valid = 1'b0;
    tick_1s      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    sample_valid = 1'b0; tick_1s = 1'b0; freeze = 1'b0;
    attention_data = '0; meditation_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // scenarios
  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({snake_speed, apple_size, level_chg, warm} !== {VW{1'b0}}) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", {snake_speed, apple_size, level_chg, warm}, {VW{1'b0}});
    end
  endtask

  task automatic test_warmup();
    do_reset();
    for (int i = 0; i < 3; i++) drive(1, 200, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    n_checks++;
    if (snake_speed !== 3'd0 || level_chg !== 1'b0 || warm !== 1'b0) begin
      n_fail++;
      $display("FAIL warmup_tick_ignored: got spd=%0d chg=%0d warm=%0d expected 0 0 0", snake_speed, level_chg, warm);
    end
    drive(1, 200, 0, 1, 0);
    n_checks++;
    if (warm !== 1'b1 || snake_speed !== 3'd0 || level_chg !== 1'b0) begin
      n_fail++;
      $display("FAIL warmup_fourth_sample: got warm=%0d spd=%0d chg=%0d expected 1 0 0", warm, snake_speed, level_chg);
    end
    for (int k = 1; k <= 8; k++) begin
      drive(0, 0, 0, 1, 0);
      n_checks++;
      if ({snake_speed, apple_size, level_chg, warm} !== model_vec() ||
          snake_speed !== LVL_W'(k > 6 ? 6 : k) || level_chg !== (k <= 6)) begin
        n_fail++;
        $display("FAIL warmup_ramp_%0d: got %h expected %h (spd %0d)", k,
                 {snake_speed, apple_size, level_chg, warm}, model_vec(), (k > 6 ? 6 : k));
      end
    end
  endtask

  task automatic test_hysteresis();
    int exp_h;
    exp_h = (HM == 4) ? 6 : 5;
    for (int i = 0; i < D; i++) drive(1, 190, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    n_checks++;
    if (snake_speed !== LVL_W'(exp_h) || {snake_speed, apple_size, level_chg, warm} !== model_vec()) begin
      n_fail++;
      $display("FAIL hyst_190: got spd=%0d expected %0d", snake_speed, exp_h);
    end
    for (int i = 0; i < D; i++) drive(1, 186, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    n_checks++;
    if (snake_speed !== 3'd5 || {snake_speed, apple_size, level_chg, warm} !== model_vec()) begin
      n_fail++;
      $display("FAIL hyst_186: got spd=%0d expected 5", snake_speed);
    end
  endtask

  task automatic test_meditation();
    for (int i = 0; i < D; i++) drive(1, 186, 255, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      drive(0, 0, 0, 1, 0);
      n_checks++;
      if (apple_size !== LVL_W'(k > 7 ? 7 : k) || {snake_speed, apple_size, level_chg, warm} !== model_vec()) begin
        n_fail++;
        $display("FAIL med_up_%0d: got %h expected %h", k, {snake_speed, apple_size, level_chg, warm}, model_vec());
      end
    end
    for (int i = 0; i < D; i++) drive(1, 186, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      drive(0, 0, 0, 1, 0);
      n_checks++;
      if (apple_size !== LVL_W'(k > 7 ? 0 : 7 - k) || level_chg !== (k <= 7) ||
          {snake_speed, apple_size, level_chg, warm} !== model_vec()) begin
        n_fail++;
        $display("FAIL med_down_%0d: got %h expected %h", k, {snake_speed, apple_size, level_chg, warm}, model_vec());
      end
    end
  endtask

  task automatic test_freeze();
    do_reset();
    for (int i = 0; i < D; i++) drive(1, 255, 255, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(1, 250, 250, 1, 1);
    n_checks++;
    if (snake_speed !== 3'd3 || apple_size !== 3'd3 || level_chg !== 1'b1) begin
      n_fail++;
      $display("FAIL freeze_same_cycle_tick: got spd=%0d apl=%0d chg=%0d expected 3 3 1", snake_speed, apple_size, level_chg);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1, 250, 250, 1, 1);
      n_checks++;
      if (snake_speed !== 3'd3 || level_chg !== 1'b0 || {snake_speed, apple_size, level_chg, warm} !== model_vec()) begin
        n_fail++;
        $display("FAIL freeze_hold_%0d: got spd=%0d chg=%0d expected 3 0", k, snake_speed, level_chg);
      end
    end
    drive(0, 0, 0, 0, 0);
    for (int k = 4; k <= 5; k++) begin
      drive(0, 0, 0, 1, 0);
      n_checks++;
      if (snake_speed !== LVL_W'(k) || {snake_speed, apple_size, level_chg, warm} !== model_vec()) begin
        n_fail++;
        $display("FAIL freeze_resume_%0d: got spd=%0d expected %0d", k, snake_speed, k);
      end
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    for (int i = 0; i < D; i++) drive(1, 40, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    n_checks++;
    if (snake_speed !== 3'd1) begin
      n_fail++;
      $display("FAIL same_cycle_setup: got spd=%0d expected 1", snake_speed);
    end
    drive(1, 255, 0, 1, 0);
    n_checks++;
    if (snake_speed !== 3'd1 || level_chg !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_old_avg: got spd=%0d chg=%0d expected 1 0", snake_speed, level_chg);
    end
    drive(0, 0, 0, 1, 0);
    n_checks++;
    if (snake_speed !== 3'd2 || level_chg !== 1'b1) begin
      n_fail++;
      $display("FAIL same_cycle_next_tick: got spd=%0d chg=%0d expected 2 1", snake_speed, level_chg);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < D; i++) drive(1, 200, 0, 0, 0);
    for (int k = 0; k < 5; k++) drive(0, 0, 0, 1, 0);
    n_checks++;
    if (snake_speed !== 3'd5) begin
      n_fail++;
      $display("FAIL reset_mid_setup: got spd=%0d expected 5", snake_speed);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({snake_speed, apple_size, level_chg, warm} !== {VW{1'b0}}) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %h expected %h", {snake_speed, apple_size, level_chg, warm}, {VW{1'b0}});
    end
    @(negedge clk);
    rst = 1'b1;
    drive(1, 200, 0, 1, 0);
    n_checks++;
    if (warm !== 1'b0 || snake_speed !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_mid_rewarm: got warm=%0d spd=%0d expected 0 0", warm, snake_speed);
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] e;
    bit fz;
    do_reset();
    fz = 0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) == 0) fz = ~fz;
      drive($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 3) == 0, fz);
      exp_q.push_back(model_vec());
      e = exp_q.pop_front();
      n_checks++;
      if ({snake_speed, apple_size, level_chg, warm} !== e) begin
        n_fail++;
        $display("FAIL random_%0d: got %h expected %h", c, {snake_speed, apple_size, level_chg, warm}, e);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    sample_valid = 1'b0; tick_1s = 1'b0; freeze = 1'b0;
    attention_data = '0; meditation_data = '0;
    model_reset();
    test_reset();
    test_warmup();
    test_hysteresis();
    test_meditation();
    test_freeze();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_para_smooth.md
# game_para_smooth

Parametrised successor of the attention-to-game-parameter mapper in the snake game. It accepts attention and meditation samples from the EEG packet parser and keeps a moving average of each over a power-of-two window. On each 1 s tick it steps `snake_speed` (from attention) and `apple_size` (from meditation) by at most one level per tick, with a hysteresis band, so parameter changes are visible rather than jumpy. It sits between the brainwave packet decoder and the snake game core.

## Interface
Parameters:
- `DATA_W`, 8: sample width.
- `LVL_W`, 3: level output width. Maximum level `LMAX = 2^LVL_W-1`.
- `AVG_LOG2`, 2: log2 of the averaging window depth `D`.
- `HYST`, 4: hysteresis margin, in sample units (must be < `2^(DATA_W-LVL_W)`).

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous active-low reset.
- `sample_valid`, in, 1: one-cycle strobe; the two data inputs are valid this cycle.
- `attention_data`, in, `DATA_W`: attention sample.
- `meditation_data`, in, `DATA_W`: meditation sample.
- `tick_1s`, in, 1: one-cycle update strobe, once per second.
- `freeze`, in, 1: hold levels (game paused).
- `snake_speed`, out, `LVL_W`: speed level.
- `apple_size`, out, `LVL_W`: apple size level.
- `level_chg`, out, 1: one-cycle pulse when either level changed.
- `warm`, out, 1: window has been filled at least once.

## Operation
- **Two identical channels** (A = attention, M = meditation). Each has a `D`-entry circular buffer, a shared write pointer, and a running sum of width `DATA_W+AVG_LOG2`.
- **Sample push:** on `sample_valid`, `sum <= sum + new - buf[wp]`, then `buf[wp] <= new` and `wp` increments, wrapping at `D`.
- **Average:** `avg = sum >> AVG_LOG2`, computed from registered sum values only.
- **Fill counter:** saturates at `D`. `warm` goes high once `D` samples have been pushed.
- **Thresholds:** `thr(k) = k << (DATA_W-LVL_W)`. Compares use `DATA_W+1` bits, so there is no underflow or overflow.
- **Step rule on `tick_1s`, per channel, current level `L`:**
  - Up: if `L < LMAX` and `avg >= thr(L+1)+HYST`, then `L <= L+1`.
  - Down: else if `L > 0` and `avg + HYST < thr(L)`, then `L <= L-1`.
  - Otherwise hold.
  - At most one step per tick per channel.
- **Outputs:** `snake_speed` is level A and `apple_size` is level M.
- **FSM states:**
  - `WARM`: buffers filling. Ticks are ignored and levels are held at 0.
  - `RUN`: the step rule is applied on each tick.
  - `HOLD`: samples are still pushed, but ticks are ignored.
- **FSM transitions:**
  - `WARM` goes to `RUN` on the cycle the fill count reaches `D`.
  - `RUN` goes to `HOLD` while `freeze` is 1.
  - `HOLD` goes to `RUN` when `freeze` is 0.
  - `freeze` during `WARM` does not stop filling. If `freeze` is still 1 once the window is full, the next state is `HOLD`.
- **Reset values:** buffers, sums, `wp`, fill count, `snake_speed`, `apple_size` are all 0. `level_chg` = 0, `warm` = 0, state = `WARM`. Asserting reset mid-run clears all of these immediately.

## Timing
- `sample_valid` at edge n: the updated sum is visible at edge n+1.
- `tick_1s` at edge n: the level updates at edge n+1, and `level_chg` pulses high for the cycle after edge n+1.
- **Sample and tick in the same cycle:** the tick uses the average *before* that sample. The sample is still pushed.
- **Back-to-back samples:** every cycle is accepted. There is no backpressure.
- **`warm`:** rises at the edge that pushes the `D`th sample. Ticks in that same cycle are still ignored.
- **`freeze` and tick in the same cycle:** if the state is `RUN` and `freeze` rises in that cycle, the tick is applied. Freeze takes effect from the next cycle.

## Configuration
- Macro: `GAME_PARA_HYST_EN`.
- **Defined:** the step rule uses the `HYST` margin as stated above.
- **Not defined:** `HYST` is treated as 0, so stepping is `avg >= thr(L+1)` up and `avg < thr(L)` down. The one-step-per-tick rate limit remains.

## Test plan
All scenarios use default parameters: `D = 4`, thresholds are multiples of 32, `HYST = 4`.
1. **Reset:** assert `rst=0` mid-run with `snake_speed=5` → all outputs are 0 at once. `warm=0` and state is `WARM` after release.
2. **Warm-up:** push three samples A=200, then tick → `snake_speed` stays 0 and `level_chg` stays 0. Push a fourth sample (`warm`=1), then give 6 ticks → `snake_speed` goes 1,2,3,4,5,6, with one `level_chg` per tick. It then stays at 6, since 200 < 224+4.
3. **Hysteresis:** at level 6, hold A=190 → stays 6 (190+4 ≥ 192). Hold A=186 → drops to 5 on the next tick. With the macro undefined, A=190 drops to 5.
4. **Meditation channel:** M=255 for 4 samples, then 7 ticks → `apple_size` reaches 7 and saturates. M=0 for 4 samples → one level decrement per tick down to 0, with no wrap below 0.
5. **Freeze:** during ramp-up, hold `freeze=1` over 3 ticks → levels unchanged, while samples still update the average. After release, ramp-up resumes from the held level.
6. **Same-cycle sample and tick:** at level 1 with avg=40, apply A=255 and tick in the same cycle → the level stays 1, because it used the old avg. The next tick steps to 2.
